// File: rtl/cv32e40p_ft_ex_sched_if.sv
// Handshake bundle between the EX-stage voter and the fault-tolerant scheduler.
// The scheduler takes the slave side; the pipeline/voter drives the master side.
interface cv32e40p_ft_ex_sched_if;
  logic       ex_ready_i;
  logic       vote_valid_i;
  logic [2:0] vote_err_i;
  logic       vote_mismatch_i;
  logic [2:0] sel_mux_ex_o;
  logic       retry_o;
  logic       stall_id_o;
  logic [2:0] unit_fault_o;
  logic       fatal_o;
  logic [1:0] state_o;

  modport slave (
    input  ex_ready_i, vote_valid_i, vote_err_i, vote_mismatch_i,
    output sel_mux_ex_o, retry_o, stall_id_o, unit_fault_o, fatal_o, state_o
  );

  modport master (
    output ex_ready_i, vote_valid_i, vote_err_i, vote_mismatch_i,
    input  sel_mux_ex_o, retry_o, stall_id_o, unit_fault_o, fatal_o, state_o
  );
endinterface

// File: rtl/cv32e40p_ft_ex_sched.sv
// Redundancy scheduler for the EX stage: tracks per-replica vote errors, degrades
// TMR -> DMR -> FAIL, and requests instruction retries on voter disagreement.
module cv32e40p_ft_ex_sched #(
  parameter int unsigned ERR_THRESHOLD = 8,
  parameter int unsigned DECAY_PERIOD  = 256,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cv32e40p_ft_ex_sched_if.slave ex_bus
);
  localparam int unsigned     DW         = $clog2(DECAY_PERIOD);
  localparam logic [3:0]      THR        = 4'(ERR_THRESHOLD);
  localparam logic [3:0]      RETRY_MAX  = 4'(MAX_RETRY);
  localparam logic [DW-1:0]   DECAY_LAST = DW'(DECAY_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_TMR   = 2'd0,
    ST_DMR   = 2'd1,
    ST_RETRY = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [2:0][3:0] r_cnt, w_cnt_next;
  logic [DW-1:0]   r_clean, w_clean_next;
  logic [3:0]      r_retry_cnt, w_retry_cnt_next, w_retry_inc;
  logic [2:0]      r_mask, w_mask_next;
  logic [2:0]      r_fault, w_fault_next;
  logic            r_retry, w_retry_next;
  logic            r_pend, w_pend_next;

  logic            w_vote, w_tmr_ctx, w_onehot, w_multi, w_mism;
  logic            w_clean_vote, w_decay, w_req;
  logic [2:0]      w_inc, w_dec, w_fault_set;
  logic [1:0]      w_pop;

  // Votes are read in TMR terms while all three replicas remain, otherwise in DMR terms;
  // this also tells a RETRY which mode it came from.
  assign w_vote       = ex_bus.vote_valid_i && (r_state != ST_FAIL);
  assign w_tmr_ctx    = (r_mask == 3'b111);
  assign w_onehot     = $onehot(ex_bus.vote_err_i);
  assign w_multi      = !$onehot0(ex_bus.vote_err_i);
  assign w_mism       = w_tmr_ctx ? w_multi : ex_bus.vote_mismatch_i;
  assign w_clean_vote = w_vote && (w_tmr_ctx ? (ex_bus.vote_err_i == 3'b000)
                                             : !ex_bus.vote_mismatch_i);
  assign w_decay      = w_clean_vote && (r_clean == DECAY_LAST);
  assign w_clean_next = !w_vote ? r_clean :
                        (w_clean_vote && !w_decay) ? r_clean + DW'(1) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_replica
      assign w_inc[gi] = w_vote && w_tmr_ctx && w_onehot && ex_bus.vote_err_i[gi] && !r_fault[gi];
      assign w_dec[gi] = w_decay && !w_inc[gi] && !r_fault[gi] && (r_cnt[gi] != 4'd0);
      assign w_cnt_next[gi] = w_inc[gi] ? ((r_cnt[gi] == 4'd15) ? r_cnt[gi] : r_cnt[gi] + 4'd1) :
                              w_dec[gi] ? r_cnt[gi] - 4'd1 : r_cnt[gi];
      assign w_fault_set[gi] = w_inc[gi] && (w_cnt_next[gi] == THR);
    end
  endgenerate

  assign w_fault_next = r_fault | w_fault_set;
  assign w_mask_next  = r_mask & ~w_fault_set;
  assign w_pop        = 2'(w_mask_next[0]) + 2'(w_mask_next[1]) + 2'(w_mask_next[2]);
  assign w_retry_inc  = r_retry_cnt + 4'd1;

  always_comb begin
    w_state_next     = r_state;
    w_retry_cnt_next = r_retry_cnt;
    w_req            = 1'b0;
    w_retry_next     = 1'b0;
    w_pend_next      = 1'b0;
    if (w_vote) begin
      if (w_pop < 2'd2) begin
        w_state_next = ST_FAIL;
      end else if (w_mism) begin
        w_retry_cnt_next = w_retry_inc;
        if (w_retry_inc > RETRY_MAX) begin
          w_state_next = ST_FAIL;
        end else begin
          w_state_next = ST_RETRY;
          w_req        = 1'b1;
        end
      end else begin
        w_retry_cnt_next = '0;
        w_state_next     = (w_pop == 2'd3) ? ST_TMR : ST_DMR;
      end
    end
    // A retry request waits for EX to be ready and is then delivered as one pulse.
    if (w_state_next != ST_FAIL) begin
      if (ex_bus.ex_ready_i) w_retry_next = w_req || r_pend;
      else                   w_pend_next  = w_req || r_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_TMR;
      r_cnt       <= '0;
      r_clean     <= '0;
      r_retry_cnt <= '0;
      r_mask      <= 3'b111;
      r_fault     <= 3'b000;
      r_retry     <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_clean     <= w_clean_next;
      r_retry_cnt <= w_retry_cnt_next;
      r_mask      <= w_mask_next;
      r_fault     <= w_fault_next;
      r_retry     <= w_retry_next;
      r_pend      <= w_pend_next;
    end
  end

  assign ex_bus.sel_mux_ex_o = r_mask;
  assign ex_bus.retry_o      = r_retry;
  assign ex_bus.stall_id_o   = (r_state == ST_RETRY) || (r_state == ST_FAIL);
  assign ex_bus.unit_fault_o = r_fault;
  assign ex_bus.fatal_o      = (r_state == ST_FAIL);
  assign ex_bus.state_o      = r_state;
endmodule
